// File: rtl/clk_enable_gen.sv
// clk_enable_gen: runtime-programmable fractional clock-enable generator.
// Every channel emits a one-cycle ce strobe at the average rate
// f_in * MUL / DIV, using a phase accumulator, so the long-run rate is exact.
//
// Ports
//   inclk0   : system clock
//   areset_n : asynchronous active-low reset
//   cfg_wr   : single-cycle configuration write strobe
//   cfg_ch   : target channel of the write
//   cfg_mul  : new MUL value (clamped to DIV when larger)
//   cfg_div  : new DIV value (0 disables the channel)
//   ce       : per-channel enable strobe, registered
//   clk_out  : per-channel toggle, flips together with each ce
//   locked   : goes high LOCK_CYCLES count edges after reset or realignment
//   cfg_err  : one-cycle pulse after an illegal or out-of-range write

module clk_enable_gen_lane #(
  parameter int           W    = 8,
  parameter logic [W-1:0] MUL0 = '0,
  parameter logic [W-1:0] DIV0 = '0
) (
  input  logic         inclk0,
  input  logic         areset_n,
  input  logic         ld_i,
  input  logic [W-1:0] mul_i,
  input  logic [W-1:0] div_i,
  input  logic         align_i,
  output logic         ce_o,
  output logic         clk_out_o
);
  logic [W-1:0] acc_q, acc_d, mul_q, mul_d, div_q, div_d;
  logic         ce_q, ce_d, tog_q, tog_d;
  logic [W:0]   nxt;

  always_comb begin
    nxt   = {1'b0, acc_q} + {1'b0, mul_q};
    acc_d = acc_q;
    mul_d = mul_q;
    div_d = div_q;
    ce_d  = 1'b0;
    tog_d = tog_q;
    if (ld_i) begin
      mul_d = mul_i;
      div_d = div_i;
    end
    if (align_i) begin
      acc_d = '0;
      tog_d = 1'b0;
    end else if (div_q != '0) begin
      // mul <= div and acc < div, so one subtraction always brings acc back below div
      if (nxt >= {1'b0, div_q}) begin
        acc_d = W'(nxt - {1'b0, div_q});
        ce_d  = 1'b1;
      end else begin
        acc_d = nxt[W-1:0];
      end
      tog_d = tog_q ^ ce_d;
    end
  end

  always_ff @(posedge inclk0 or negedge areset_n) begin
    if (!areset_n) begin
      acc_q <= '0;
      mul_q <= MUL0;
      div_q <= DIV0;
      ce_q  <= 1'b0;
      tog_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      mul_q <= mul_d;
      div_q <= div_d;
      ce_q  <= ce_d;
      tog_q <= tog_d;
    end
  end

  assign ce_o      = ce_q;
  assign clk_out_o = tog_q;
endmodule

module clk_enable_gen #(
  parameter int                  NUM_CH      = 3,
  parameter int                  W           = 8,
  parameter int                  LOCK_CYCLES = 16,
  parameter logic [NUM_CH*W-1:0] MUL_INIT    = {8'd12, 8'd1, 8'd1},
  parameter logic [NUM_CH*W-1:0] DIV_INIT    = {8'd25, 8'd2, 8'd1}
) (
  input  logic              inclk0,
  input  logic              areset_n,
  input  logic              cfg_wr,
  input  logic [2:0]        cfg_ch,
  input  logic [W-1:0]      cfg_mul,
  input  logic [W-1:0]      cfg_div,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked,
  output logic              cfg_err
);
  localparam logic       ST_COUNT = 1'b0;
  localparam logic       ST_ALIGN = 1'b1;
  localparam int         CW       = $clog2(LOCK_CYCLES);
  localparam logic [3:0] NCH4     = 4'(NUM_CH);

  logic          state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          locked_q, locked_d, err_q, err_d;
  logic          ch_ok, legal_wr, align;
  logic [W-1:0]  mul_c;
  logic [NUM_CH-1:0] ld;

  assign ch_ok    = {1'b0, cfg_ch} < NCH4;
  assign legal_wr = cfg_wr && ch_ok;
  assign mul_c    = (cfg_mul > cfg_div) ? cfg_div : cfg_mul;
  // The write edge and the ALIGN edge both load the aligned state, so the
  // ALIGN cycle itself already shows all-zero outputs.
  assign align    = legal_wr || (state_q == ST_ALIGN);

  always_comb begin
    state_d    = legal_wr ? ST_ALIGN : ST_COUNT;
    err_d      = cfg_wr && (!ch_ok || (cfg_div == '0) || (cfg_mul > cfg_div));
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (align) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else if (!locked_q) begin
      if (lock_cnt_q == CW'(LOCK_CYCLES - 1)) locked_d = 1'b1;
      else                                    lock_cnt_d = lock_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge inclk0 or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= ST_COUNT;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign ld[i] = legal_wr && (cfg_ch == 3'(i));
    clk_enable_gen_lane #(
      .W   (W),
      .MUL0(MUL_INIT[i*W +: W]),
      .DIV0(DIV_INIT[i*W +: W])
    ) u_lane (
      .inclk0   (inclk0),
      .areset_n (areset_n),
      .ld_i     (ld[i]),
      .mul_i    (mul_c),
      .div_i    (cfg_div),
      .align_i  (align),
      .ce_o     (ce[i]),
      .clk_out_o(clk_out[i])
    );
  end

  assign locked  = locked_q;
  assign cfg_err = err_q;
endmodule
